// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer in front of a NUM_REGS x 32-bit register bank.
// Every access phase gets WAIT_CYCLES wait states before a one-cycle pready
// response. Misaligned or out-of-range addresses return pslverr.
module apb_slave_regs #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam int          IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // BASE_ADDR is word aligned, so decode is done on word addresses.
  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   wdata;
    logic          write;
    logic          err;
  } req_t;

  logic [NUM_REGS-1:0][31:0] regs;
  state_t                    state;
  logic [3:0]                cnt;
  req_t                      req;

  logic [29:0] woff;
  req_t        dec_req;
  logic [31:0] rd_dec, rd_lat;

  // Read data is zero for writes and for errored accesses.
  function automatic logic [31:0] rsel(input req_t r,
                                       input logic [NUM_REGS-1:0][31:0] rf);
    return (r.err || r.write) ? 32'h0 : rf[r.idx];
  endfunction

  // Decode the live bus for the setup phase; rd_lat serves the latched request.
  always_comb begin
    woff          = paddr[31:2] - BASE_W;
    dec_req.idx   = woff[IW-1:0];
    dec_req.wdata = pwdata;
    dec_req.write = pwrite;
    dec_req.err   = (paddr[1:0] != 2'b00) || (paddr[31:2] < BASE_W) ||
                    (woff >= 30'(NUM_REGS));
    rd_dec        = rsel(dec_req, regs);
    rd_lat        = rsel(req, regs);
  end

  // Transfer FSM; pready/pslverr/prdata are loaded on RESP entry, cleared on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      req     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (psel && !penable) begin
            req <= dec_req;
            if (WAIT_CYCLES == 0) begin
              state   <= S_RESP;
              pready  <= 1'b1;
              pslverr <= dec_req.err;
              prdata  <= rd_dec;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state   <= S_RESP;
            pready  <= 1'b1;
            pslverr <= req.err;
            prdata  <= rd_lat;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state   <= S_IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register bank: a write commits only on a completing, error-free RESP cycle.
  always_ff @(posedge clk) begin
    if (rst)
      regs <= '0;
    else if (state == S_RESP && psel && penable && req.write && !req.err)
      regs[req.idx] <= req.wdata;
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb_apb_slave_regs: four DUT configurations driven in parallel. Each driver
// pushes the expected response into a queue; a per-instance monitor pops and
// compares whenever a transfer completes.
module tb_apb_slave_regs;

  localparam int NCFG = 4;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk;
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int inst, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cfg%0d %s: got %h, expected %h", inst, nm, act, exp);
    end
  endtask

  task automatic flag(input int inst, input string nm);
    vectors++;
    miscompares++;
    $display("FAIL cfg%0d %s", inst, nm);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int          WC = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 2;
    localparam int          NR = (g == 3) ? 5 : 8;
    localparam logic [31:0] BA = (g == 3) ? 32'h0000_0100 : 32'h0;

    logic        rst, psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;
    logic [31:0] mregs [NR];
    exp_t        q [$];
    bit          done;
    logic        prev_rdy;

    apb_slave_regs #(.NUM_REGS(NR), .WAIT_CYCLES(WC), .BASE_ADDR(BA)) dut (
      .clk(clk), .rst(rst), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
      .psel(psel), .penable(penable), .pready(pready), .prdata(prdata),
      .pslverr(pslverr)
    );

    function automatic bit exp_err(input logic [31:0] a);
      if (a[1:0] != 2'b00) return 1'b1;
      if (a < BA) return 1'b1;
      return ((a - BA) >> 2) >= 32'(NR);
    endfunction

    function automatic void model_clear();
      for (int i = 0; i < NR; i++) mregs[i] = 32'h0;
    endfunction

    // Full transfer; bus signals are scrambled during the access phase since
    // the completer must use what it latched at setup.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input bit wr);
      exp_t x;
      int   waits;
      int   idx;
      bit   e;
      e     = exp_err(a);
      idx   = int'((a - BA) >> 2);
      x.err = e;
      x.rd  = (!wr && !e) ? mregs[idx] : 32'h0;
      q.push_back(x);
      if (wr && !e) mregs[idx] = d;
      paddr = a; pwdata = d; pwrite = wr; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
      waits = 0;
      forever begin
        @(negedge clk);
        if (pready) break;
        waits++;
        if (waits > 40) begin
          flag(g, "pready_timeout");
          break;
        end
      end
      chk(g, "wait_states", 32'(waits), 32'(WC));
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
    endtask

    // Master drops psel before the response; nothing must commit.
    task automatic abandon(input logic [31:0] a, input logic [31:0] d);
      int nacc;
      nacc = (WC >= 2) ? 1 : 0;
      paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < nacc; i++) begin
        penable = 1'b1;
        @(negedge clk);
        chk(g, "abandon_wait_rdy", 32'(pready), 32'd0);
        @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk(g, "abandon_after_rdy", 32'(pready), 32'd0);
      @(posedge clk); #1;
    endtask

    // Reset lands mid-transfer (second wait cycle when there is one).
    task automatic rst_xfer(input logic [31:0] a, input logic [31:0] d);
      int nacc;
      nacc = (WC >= 2) ? 1 : 0;
      paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      if (WC == 0) begin
        rst = 1'b1;
      end else begin
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (nacc) begin @(posedge clk); #1; end
        rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      model_clear();
      chk(g, "rst_rdy", 32'(pready), 32'd0);
      @(posedge clk); #1;
      chk(g, "rst_rdy_after", 32'(pready), 32'd0);
    endtask

    // Monitor: response check on completion, quiet outputs otherwise.
    always @(negedge clk) begin
      if (!rst) begin
        if (pready) begin
          chk(g, "rdy_pulse", 32'(prev_rdy), 32'd0);
          if (psel && penable) begin
            if (q.size() == 0) begin
              flag(g, "unexpected_completion");
            end else begin
              chk(g, "prdata", prdata, q[0].rd);
              chk(g, "pslverr", 32'(pslverr), 32'(q[0].err));
              void'(q.pop_front());
            end
          end
        end else begin
          chk(g, "idle_prdata", prdata, 32'h0);
          chk(g, "idle_pslverr", 32'(pslverr), 32'd0);
        end
      end
      prev_rdy <= pready;
    end

    initial begin
      logic [31:0] a;
      done = 1'b0;
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk(g, "rst_pready", 32'(pready), 32'd0);
      chk(g, "rst_pslverr", 32'(pslverr), 32'd0);
      chk(g, "rst_prdata", prdata, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      xfer(BA + 32'h4, 32'h0, 1'b0);
      xfer(BA + 32'h4, 32'h1234_5678, 1'b1);
      xfer(BA + 32'h4, 32'h0, 1'b0);
      // back-to-back, no idle gap
      xfer(BA + 32'h0,  32'hA5A5_A5A5, 1'b1);
      xfer(BA + 32'h1C, 32'h0000_FFFF, 1'b1);
      xfer(BA + 32'h0,  32'h0, 1'b0);
      xfer(BA + 32'h1C, 32'h0, 1'b0);
      // errors
      xfer(BA + 32'h6,  32'hDEAD_BEEF, 1'b1);
      xfer(BA + 32'h20, 32'h0BAD_0BAD, 1'b1);
      xfer(BA + 32'h20, 32'h0, 1'b0);
      xfer(BA - 32'h4,  32'h0, 1'b0);
      xfer(BA + 32'h4,  32'h0, 1'b0);
      // abandoned write leaves reg[3] alone
      xfer(BA + 32'hC, 32'h3333_3333, 1'b1);
      abandon(BA + 32'hC, 32'hCAFE_F00D);
      xfer(BA + 32'hC, 32'h0, 1'b0);
      // reset mid-write clears the bank and drops the write
      xfer(BA + 32'h8, 32'h2222_2222, 1'b1);
      rst_xfer(BA + 32'h8, 32'h1111_1111);
      xfer(BA + 32'h8, 32'h0, 1'b0);
      xfer(BA + 32'h4, 32'h0, 1'b0);

      repeat (60) begin
        a = BA + 32'(4 * $urandom_range(0, NR + 1));
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) a = BA - 32'h4;
        xfer(a, $urandom, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < NR; i++) xfer(BA + 32'(4 * i), 32'h0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk(g, "queue_drained", 32'(q.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    vectors = 0;
    miscompares = 0;
    t = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done)
           && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 60000) flag(-1, "global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
